scbsng_pair: RTL and testbench
==============================

Name: scbsng_pair

Overview:
- Paired stochastic number generator. Converts two binary operands into a dividend/divisor bitstream pair of programmable length, plus a random select bit.
- Drives the in-stream correlation-based divider datapath; it is the transmitter side of that bitstream interface.
- Correlation between the two streams is selectable per run: a shared random source gives positively correlated streams, independent sources give uncorrelated ones.

Parameters:
- WIDTH, 8, operand and LFSR width; legal values 8 or 16.
- LEN_W, 16, width of the stream-length field.
- SEED_A, 8'hA5, seed of LFSR A (dividend source, and divisor source when corr=1).
- SEED_B, 8'h3C, seed of LFSR B (divisor source when corr=0).
- SEED_C, 8'h71, seed of LFSR C (rand_bit source).
- Any seed equal to 0 is replaced by 1 at elaboration.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a run; sampled only in IDLE.
- dividend_bin  in  WIDTH  dividend operand x.
- divisor_bin  in  WIDTH  divisor operand y.
- len  in  LEN_W  stream length in bits.
- corr  in  1  1 = shared source (correlated), 0 = independent sources.
- busy  out  1  run in progress.
- valid  out  1  stream bits valid this cycle.
- dividend  out  1  dividend bitstream.
- divisor  out  1  divisor bitstream.
- rand_bit  out  1  random select bit for the divider.
- done  out  1  one-cycle end-of-run pulse.
- dividend_cnt  out  LEN_W  ones count on dividend (optional feature).
- divisor_cnt  out  LEN_W  ones count on divisor (optional feature).

Behaviour:
- Reset: all outputs 0; state IDLE; LFSRs loaded with their seeds; operand and length latches cleared. Reset asserted mid-run aborts the run immediately, with no done pulse.
- LFSRs are WIDTH-bit Galois, maximal length, and never reach 0.
  - Polynomial for WIDTH=8: x^8+x^6+x^5+x^4+1.
  - Polynomial for WIDTH=16: x^16+x^14+x^13+x^11+1.
  - LFSRs step only in RUN, once per cycle.
- Bit rule, registered: dividend <= (rnA <= x_q); divisor <= (rnS <= y_q), where rnS = corr_q ? rnA : rnB; rand_bit <= rnC[0].
  - x=0 gives all zeros.
  - x=2^WIDTH-1 gives all ones.
  - Over len = 2^WIDTH-1 bits, the ones count equals x exactly.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches x, y, len and corr, and reloads all LFSRs to seed. Next state is RUN if len != 0, else DONE.
  - RUN: emits one bit pair per cycle and increments the cycle counter. On the cycle emitting bit len_q-1, next state is DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Timing, with start sampled at edge k:
  - busy=1 from cycle k+1 through the DONE cycle.
  - valid=1 for exactly len_q consecutive cycles starting at k+1.
  - done is asserted in the cycle after the last valid.
  - If len=0: done is asserted in cycle k+1 and valid is never asserted.
- When valid=0, dividend, divisor and rand_bit are 0.
- start while busy is ignored; latched inputs are not disturbed. Input changes during RUN have no effect.
- start held high in the DONE cycle is ignored; a new run needs start in IDLE. Back-to-back runs therefore have one IDLE cycle between them.
- With corr=1 and x <= y: divisor=1 in every cycle where dividend=1. The divider requires this, since the divisor is never smaller than the dividend.
- The cycle counter is LEN_W bits wide and does not wrap; the maximum run length is 2^LEN_W-1.

Optional Feature:
- Macro: SCBSNG_CNT_EN.
- Defined:
  - dividend_cnt and divisor_cnt count ones emitted during the run.
  - Both clear to 0 when start is accepted.
  - Both hold their final value from the DONE cycle until the next accepted start.
  - Both are 0 on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Reset -> all outputs 0. Reset asserted during RUN at bit 50 of 200 -> outputs 0 next cycle, no done pulse, state IDLE.
- WIDTH=8, x=100, y=200, len=255, corr=1 -> exactly 100 and 200 ones; dividend=1 implies divisor=1 in all 255 cycles; done at cycle 256; counts 100/200 with SCBSNG_CNT_EN.
- Same operands with corr=0 -> still 100/200 ones; at least one cycle with dividend=1 and divisor=0.
- x=0, y=255, len=255 -> dividend never 1, divisor always 1. len=0 -> done at k+1, valid never asserted.
- start pulsed during RUN with different x -> ignored; run completes with the original x and len; the bit sequence matches a golden LFSR model.
- Two runs with identical inputs -> identical bitstreams, since the LFSRs reload on each start; one IDLE cycle between done and the second busy.

Source files
------------

// File: rtl/scbsng_pair.sv
// -----------------------------------------------------------------------------
// scbsng_pair
//
// Paired stochastic number generator. Turns two binary operands into a
// dividend/divisor bitstream pair of programmable length, plus a random select
// bit, for the in-stream correlation-based divider datapath. This block is the
// transmitter side of that bitstream interface.
//
// Each stream bit is produced by comparing a pseudo-random number with the
// operand: bit = (rn <= operand). With corr=1 both streams share LFSR A, so the
// streams are positively correlated. With corr=0 the divisor uses LFSR B and
// the streams are independent. LFSR C drives rand_bit.
//
// Parameters:
//   WIDTH   operand and LFSR width, 8 or 16
//   LEN_W   width of the stream-length field
//   SEED_A  seed of LFSR A (dividend, and divisor when corr=1)
//   SEED_B  seed of LFSR B (divisor when corr=0)
//   SEED_C  seed of LFSR C (rand_bit)
//   A seed of 0 is replaced by 1, because an all-zero LFSR would stick.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request a run (only looked at in IDLE)
//   dividend_bin    dividend operand x
//   divisor_bin     divisor operand y
//   len             stream length in bits
//   corr            1 = shared random source, 0 = independent sources
//   busy            run in progress (RUN or DONE)
//   valid           stream bits valid this cycle
//   dividend        dividend bitstream
//   divisor         divisor bitstream
//   rand_bit        random select bit for the divider
//   done            one-cycle end-of-run pulse
//   dividend_cnt    ones emitted on dividend (optional counters)
//   divisor_cnt     ones emitted on divisor (optional counters)
//
// Optional feature macro: SCBSNG_CNT_EN
//   Defined   : dividend_cnt/divisor_cnt count the ones of the current run.
//   Undefined : both count ports are tied to 0 and no counter logic exists.
// -----------------------------------------------------------------------------
module scbsng_pair #(
    parameter int               WIDTH  = 8,
    parameter int               LEN_W  = 16,
    parameter logic [WIDTH-1:0] SEED_A = 8'hA5,
    parameter logic [WIDTH-1:0] SEED_B = 8'h3C,
    parameter logic [WIDTH-1:0] SEED_C = 8'h71
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_bin,
    input  logic [WIDTH-1:0] divisor_bin,
    input  logic [LEN_W-1:0] len,
    input  logic             corr,
    output logic             busy,
    output logic             valid,
    output logic             dividend,
    output logic             divisor,
    output logic             rand_bit,
    output logic             done,
    output logic [LEN_W-1:0] dividend_cnt,
    output logic [LEN_W-1:0] divisor_cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [WIDTH-1:0] SEED_A_L = (SEED_A == '0) ? ONE : SEED_A;
    localparam logic [WIDTH-1:0] SEED_B_L = (SEED_B == '0) ? ONE : SEED_B;
    localparam logic [WIDTH-1:0] SEED_C_L = (SEED_C == '0) ? ONE : SEED_C;

    // Right-shifting Galois feedback masks.
    // WIDTH=8 : x^8+x^6+x^5+x^4+1     -> 0xB8
    // WIDTH=16: x^16+x^14+x^13+x^11+1 -> 0xB400
    localparam logic [WIDTH-1:0] TAPS = (WIDTH == 16) ? WIDTH'(16'hB400)
                                                      : WIDTH'(8'hB8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Galois step: shift right, fold the taps in when a one falls out.
    // Maximal-length taps mean a nonzero state never reaches zero.
    function automatic logic [WIDTH-1:0] lfsrStep(input logic [WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsrA_q, lfsrA_d;
    logic [WIDTH-1:0] lfsrB_q, lfsrB_d;
    logic [WIDTH-1:0] lfsrC_q, lfsrC_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             corr_q, corr_d;
    logic [LEN_W-1:0] bitCnt_q, bitCnt_d;
    logic             dividend_q, dividend_d;
    logic             divisor_q, divisor_d;
    logic             randBit_q, randBit_d;

    logic [WIDTH-1:0] rnA, rnB, rnC, rnS;
    logic [WIDTH-1:0] xCmp, yCmp;
    logic             corrSel;
    logic             emit;
    logic             accept;

    assign accept = (state_q == IDLE) && start;

    // Next-state and stream generation.
    // Stream bits are registered so that they line up with the RUN state:
    // the first bit is computed on the edge that accepts start, straight from
    // the seeds and the live operand inputs, and every later bit on the edge
    // that stays in RUN. bitCnt_q is the number of bits already presented, so
    // reaching len_q means the last bit is on the outputs and DONE follows.
    // Leaving RUN forces the stream outputs to 0.
    always_comb begin
        state_d    = state_q;
        lfsrA_d    = lfsrA_q;
        lfsrB_d    = lfsrB_q;
        lfsrC_d    = lfsrC_q;
        x_d        = x_q;
        y_d        = y_q;
        len_d      = len_q;
        corr_d     = corr_q;
        bitCnt_d   = bitCnt_q;
        dividend_d = 1'b0;
        divisor_d  = 1'b0;
        randBit_d  = 1'b0;
        rnA        = lfsrA_q;
        rnB        = lfsrB_q;
        rnC        = lfsrC_q;
        rnS        = lfsrA_q;
        xCmp       = x_q;
        yCmp       = y_q;
        corrSel    = corr_q;
        emit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = dividend_bin;
                    y_d      = divisor_bin;
                    len_d    = len;
                    corr_d   = corr;
                    lfsrA_d  = SEED_A_L;
                    lfsrB_d  = SEED_B_L;
                    lfsrC_d  = SEED_C_L;
                    rnA      = SEED_A_L;
                    rnB      = SEED_B_L;
                    rnC      = SEED_C_L;
                    xCmp     = dividend_bin;
                    yCmp     = divisor_bin;
                    corrSel  = corr;
                    bitCnt_d = '0;
                    if (len != '0) begin
                        emit    = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (bitCnt_q == len_q) begin
                    state_d = DONE;
                end else begin
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit) begin
            rnS        = corrSel ? rnA : rnB;
            dividend_d = (rnA <= xCmp);
            divisor_d  = (rnS <= yCmp);
            randBit_d  = rnC[0];
            lfsrA_d    = lfsrStep(rnA);
            lfsrB_d    = lfsrStep(rnB);
            lfsrC_d    = lfsrStep(rnC);
            bitCnt_d   = bitCnt_d + LEN_W'(1);
        end
    end

    // State, LFSR, latch and stream registers. Reset aborts any run at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsrA_q    <= SEED_A_L;
            lfsrB_q    <= SEED_B_L;
            lfsrC_q    <= SEED_C_L;
            x_q        <= '0;
            y_q        <= '0;
            len_q      <= '0;
            corr_q     <= 1'b0;
            bitCnt_q   <= '0;
            dividend_q <= 1'b0;
            divisor_q  <= 1'b0;
            randBit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsrA_q    <= lfsrA_d;
            lfsrB_q    <= lfsrB_d;
            lfsrC_q    <= lfsrC_d;
            x_q        <= x_d;
            y_q        <= y_d;
            len_q      <= len_d;
            corr_q     <= corr_d;
            bitCnt_q   <= bitCnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            randBit_q  <= randBit_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign valid    = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign dividend = dividend_q;
    assign divisor  = divisor_q;
    assign rand_bit = randBit_q;

`ifdef SCBSNG_CNT_EN
    logic [LEN_W-1:0] divOnes_q, divOnes_d;
    logic [LEN_W-1:0] dvsOnes_q, dvsOnes_d;

    // Ones counters accumulate the bits actually presented on the outputs.
    // They trail the stream by a cycle during RUN; the edge into DONE adds
    // the last bit, so the totals are final in the DONE cycle and then hold
    // until the next accepted start clears them.
    always_comb begin
        divOnes_d = divOnes_q;
        dvsOnes_d = dvsOnes_q;
        if (accept) begin
            divOnes_d = '0;
            dvsOnes_d = '0;
        end else if (state_q == RUN) begin
            divOnes_d = divOnes_q + LEN_W'(dividend_q);
            dvsOnes_d = dvsOnes_q + LEN_W'(divisor_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divOnes_q <= '0;
            dvsOnes_q <= '0;
        end else begin
            divOnes_q <= divOnes_d;
            dvsOnes_q <= dvsOnes_d;
        end
    end

    assign dividend_cnt = divOnes_q;
    assign divisor_cnt  = dvsOnes_q;
`else
    assign dividend_cnt = '0;
    assign divisor_cnt  = '0;
`endif

endmodule

// File: tb/tb_scbsng_pair.sv
// -----------------------------------------------------------------------------
// tb_scbsng_pair
//
// Directed bench for scbsng_pair with WIDTH=8. A small golden LFSR model
// predicts every stream bit; hand-derived totals (ones counts, lengths, done
// timing) are checked alongside it.
// -----------------------------------------------------------------------------
module tb_scbsng_pair;

    localparam int WIDTH = 8;
    localparam int LEN_W = 16;
    localparam int LIMIT = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend_bin;
    logic [WIDTH-1:0] divisor_bin;
    logic [LEN_W-1:0] len;
    logic             corr;
    logic             busy;
    logic             valid;
    logic             dividend;
    logic             divisor;
    logic             rand_bit;
    logic             done;
    logic [LEN_W-1:0] dividend_cnt;
    logic [LEN_W-1:0] divisor_cnt;

    int errCount   = 0;
    int checkCount = 0;

    int nValid, onesA, onesB, viol, seqErr, busyErr;
    logic [255:0] capA, capB, capA1, capB1;
    int doneSeen;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    scbsng_pair #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dividend_bin (dividend_bin),
        .divisor_bin  (divisor_bin),
        .len          (len),
        .corr         (corr),
        .busy         (busy),
        .valid        (valid),
        .dividend     (dividend),
        .divisor      (divisor),
        .rand_bit     (rand_bit),
        .done         (done),
        .dividend_cnt (dividend_cnt),
        .divisor_cnt  (divisor_cnt)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Golden Galois step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] modelStep(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Present operands with a one-cycle start pulse; returns #1 after the
    // accepting edge, i.e. in the first cycle of the run.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                 input logic [15:0] l, input logic c);
        dividend_bin = x;
        divisor_bin  = y;
        len          = l;
        corr         = c;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
    endtask

    // Walk the valid window against the golden model. Optionally pulses start
    // with different operands at valid bit index disturbAt. Returns in the
    // first cycle after the window.
    task automatic collectRun(input logic [7:0] x, input logic [7:0] y,
                              input logic c, input int disturbAt);
        logic [7:0] sA, sB, sC;
        logic expA, expB, expR;
        sA = 8'hA5;
        sB = 8'h3C;
        sC = 8'h71;
        nValid = 0; onesA = 0; onesB = 0; viol = 0; seqErr = 0; busyErr = 0;
        capA = '0;
        capB = '0;
        while (valid === 1'b1 && nValid < LIMIT) begin
            expA = (sA <= x);
            expB = ((c ? sA : sB) <= y);
            expR = sC[0];
            if (dividend !== expA || divisor !== expB || rand_bit !== expR)
                seqErr++;
            if (busy !== 1'b1 || done !== 1'b0)
                busyErr++;
            if (dividend === 1'b1) onesA++;
            if (divisor === 1'b1) onesB++;
            if (dividend === 1'b1 && divisor === 1'b0) viol++;
            if (nValid < 256) begin
                capA[nValid] = dividend;
                capB[nValid] = divisor;
            end
            sA = modelStep(sA);
            sB = modelStep(sB);
            sC = modelStep(sC);
            if (nValid == disturbAt) begin
                start        = 1'b1;
                dividend_bin = 8'd200;
                divisor_bin  = 8'd3;
                len          = 16'd5;
                corr         = ~c;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            nValid++;
        end
        start = 1'b0;
        checkOutput("valid_bound", 32'(nValid < LIMIT), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        dividend_bin = '0;
        divisor_bin  = '0;
        len          = '0;
        corr         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_streams", 32'({dividend, divisor, rand_bit}), 32'd0);
        checkOutput("rst_cnts", 32'({dividend_cnt, divisor_cnt}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Correlated full-period run: ones counts equal the operands exactly.
        $display("[TB] corr=1 x=100 y=200 len=255");
        applyStimulus(8'd100, 8'd200, 16'd255, 1'b1);
        collectRun(8'd100, 8'd200, 1'b1, -1);
        checkOutput("c1_len", 32'(nValid), 32'd255);
        checkOutput("c1_onesA", 32'(onesA), 32'd100);
        checkOutput("c1_onesB", 32'(onesB), 32'd200);
        checkOutput("c1_implication", 32'(viol), 32'd0);
        checkOutput("c1_sequence", 32'(seqErr), 32'd0);
        checkOutput("c1_busy", 32'(busyErr), 32'd0);
        checkOutput("c1_done_cycle", 32'(nValid + 1), 32'd256);
        checkOutput("c1_done", 32'(done), 32'd1);
        checkOutput("c1_done_busy", 32'(busy), 32'd1);
        checkOutput("c1_done_quiet", 32'({valid, dividend, divisor, rand_bit}), 32'd0);
`ifdef SCBSNG_CNT_EN
        checkOutput("c1_cntA", 32'(dividend_cnt), 32'd100);
        checkOutput("c1_cntB", 32'(divisor_cnt), 32'd200);
`else
        checkOutput("c1_cntA", 32'(dividend_cnt), 32'd0);
        checkOutput("c1_cntB", 32'(divisor_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        checkOutput("c1_idle_done", 32'(done), 32'd0);
        checkOutput("c1_idle_busy", 32'(busy), 32'd0);
`ifdef SCBSNG_CNT_EN
        checkOutput("c1_cnt_hold", 32'(dividend_cnt), 32'd100);
`endif

        // Independent sources: same totals, implication no longer guaranteed.
        $display("[TB] corr=0 x=100 y=200 len=255");
        applyStimulus(8'd100, 8'd200, 16'd255, 1'b0);
        collectRun(8'd100, 8'd200, 1'b0, -1);
        checkOutput("c0_len", 32'(nValid), 32'd255);
        checkOutput("c0_onesA", 32'(onesA), 32'd100);
        checkOutput("c0_onesB", 32'(onesB), 32'd200);
        checkOutput("c0_has_violation", 32'(viol != 0), 32'd1);
        checkOutput("c0_sequence", 32'(seqErr), 32'd0);
        checkOutput("c0_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;

        // Operand extremes.
        $display("[TB] x=0 y=255 len=255");
        applyStimulus(8'd0, 8'd255, 16'd255, 1'b1);
        collectRun(8'd0, 8'd255, 1'b1, -1);
        checkOutput("ext_onesA", 32'(onesA), 32'd0);
        checkOutput("ext_onesB", 32'(onesB), 32'd255);
        checkOutput("ext_sequence", 32'(seqErr), 32'd0);
        @(posedge clk);
        #1;

        // Zero length: done right away, never valid.
        $display("[TB] len=0");
        applyStimulus(8'd10, 8'd20, 16'd0, 1'b1);
        checkOutput("len0_valid", 32'(valid), 32'd0);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("len0_after", 32'({busy, done, valid}), 32'd0);

        // start during RUN with new operands must be ignored.
        $display("[TB] start during run");
        applyStimulus(8'd50, 8'd80, 16'd40, 1'b0);
        collectRun(8'd50, 8'd80, 1'b0, 10);
        checkOutput("dist_len", 32'(nValid), 32'd40);
        checkOutput("dist_sequence", 32'(seqErr), 32'd0);
        checkOutput("dist_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back identical runs, start held through DONE.
        $display("[TB] back-to-back runs");
        applyStimulus(8'd77, 8'd150, 16'd30, 1'b1);
        collectRun(8'd77, 8'd150, 1'b1, -1);
        capA1 = capA;
        capB1 = capB;
        checkOutput("b2b_len1", 32'(nValid), 32'd30);
        checkOutput("b2b_seq1", 32'(seqErr), 32'd0);
        checkOutput("b2b_done1", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_gap_busy", 32'(busy), 32'd0);
        checkOutput("b2b_gap_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_restart", 32'({busy, valid}), 32'd3);
        collectRun(8'd77, 8'd150, 1'b1, -1);
        checkOutput("b2b_len2", 32'(nValid), 32'd30);
        checkOutput("b2b_seq2", 32'(seqErr), 32'd0);
        checkOutput("b2b_sameA", 32'(capA == capA1), 32'd1);
        checkOutput("b2b_sameB", 32'(capB == capB1), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a run: abort, no done pulse.
        $display("[TB] reset during run");
        applyStimulus(8'd100, 8'd200, 16'd200, 1'b1);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("mid_running", 32'(valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_out", 32'({busy, valid, done, dividend, divisor, rand_bit}), 32'd0);
        checkOutput("mid_rst_cnt", 32'({dividend_cnt, divisor_cnt}), 32'd0);
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkOutput("mid_no_done", 32'(doneSeen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
